// File: rtl/axis_harness_pkg.sv
// Shared defaults and beat type for the stream harness stages.
package axis_harness_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 32;

  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// FIFO storage: register array, one synchronous write port, asynchronous read port.
module axis_fifo_mem #(
  parameter int W     = 17,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are deliberately never reset; level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_vpi_sink_fifo.sv
// FWFT sink FIFO between the VPI stimulus task and the DUT stream input,
// with beat/packet counters and a sticky upstream-stall flag.
module axis_vpi_sink_fifo
  import axis_harness_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         beat_cnt,
  output logic [CNT_W-1:0]         pkt_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic          push, pop;
  logic [DATA_W:0] rd_word;

  assign s_tready = (level_q != LW'(DEPTH));
  assign m_tvalid = (level_q != '0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign level    = level_q;
  assign m_tdata  = rd_word[DATA_W-1:0];
  assign m_tlast  = rd_word[DATA_W];

  axis_fifo_mem #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({s_tlast, s_tdata}),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (push) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (s_tlast) pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
      if (s_tvalid && !s_tready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_vpi_sink_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axis_vpi_sink_fifo;
  import axis_harness_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b0;

  logic        s_tready, m_tvalid, m_tlast, overflow;
  logic [15:0] m_tdata;
  logic [3:0]  level;
  logic [31:0] beat_cnt, pkt_cnt;

  logic        s_tready2, m_tvalid2, m_tlast2, overflow2;
  logic [15:0] m_tdata2;
  logic [3:0]  level2;
  logic [3:0]  beat_cnt2, pkt_cnt2;

  always #5 clk = ~clk;

  axis_vpi_sink_fifo #(.DATA_W(16), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .level(level), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt),
    .overflow(overflow)
  );

  axis_vpi_sink_fifo #(.DATA_W(16), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready2), .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2),
    .m_tready(m_tready), .level(level2), .beat_cnt(beat_cnt2), .pkt_cnt(pkt_cnt2),
    .overflow(overflow2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of beats plus plain counters.
  beat_t       q[$];
  int unsigned m_beats = 0;
  int unsigned m_pkts = 0;
  bit          m_ovf = 1'b0;
  bit          m_pushed = 1'b0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    bit do_push, do_pop;
    beat_t b;
    if (rst) begin
      q.delete();
      m_beats = 0; m_pkts = 0; m_ovf = 1'b0; m_pushed = 1'b0;
      started = 1'b1;
    end else begin
      do_push = s_tvalid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && m_tready;
      if (s_tvalid && q.size() == DEPTH) m_ovf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        b.last = s_tlast; b.data = s_tdata;
        q.push_back(b);
        m_beats++;
        if (s_tlast) m_pkts++;
      end
      m_pushed = do_push;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("level",    32'(level),     32'(q.size()));
      chk("m_tvalid", 32'(m_tvalid),  32'(q.size() != 0));
      chk("s_tready", 32'(s_tready),  32'(q.size() != DEPTH));
      chk("beat_cnt", beat_cnt,       m_beats);
      chk("pkt_cnt",  pkt_cnt,        m_pkts);
      chk("overflow", 32'(overflow),  32'(m_ovf));
      chk("beat_cnt4", 32'(beat_cnt2), m_beats % 16);
      chk("pkt_cnt4",  32'(pkt_cnt2),  m_pkts % 16);
      if (q.size() != 0) begin
        chk("m_tdata", 32'(m_tdata), 32'(q[0].data));
        chk("m_tlast", 32'(m_tlast), 32'(q[0].last));
      end
    end
  end

  task automatic step(input bit v, input logic [15:0] d, input bit l, input bit r);
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bit v, l, r;
    logic [15:0] d;
    int unsigned vprob, rprob;

    // Reset state
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd1);
    chk("rst_beat", beat_cnt, 32'd0);
    chk("rst_pkt", pkt_cnt, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single push, no drain
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    s_tvalid = 1'b0;
    chk("p1_mvalid", 32'(m_tvalid), 32'd1);
    chk("p1_mdata", 32'(m_tdata), 32'h5555);
    chk("p1_level", 32'(level), 32'd1);
    chk("p1_beat", beat_cnt, 32'd1);

    // Fill to full, stall one beat, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd8);
    chk("full_sready", 32'(s_tready), 32'd0);
    step(1'b1, 16'h0008, 1'b0, 1'b0);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_beat", beat_cnt, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(m_tdata), 32'(i));
      step(1'b0, 16'h0, 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(m_tvalid), 32'd0);

    // Continuous streaming, pointers wrap twice
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'(16'h0100 + i), (i == 19), 1'b1);
      chk("str_level", 32'(level), 32'd1);
      chk("str_data", 32'(m_tdata), 32'(16'h0100 + i));
    end
    chk("str_beat", beat_cnt, 32'd20);
    chk("str_pkt", pkt_cnt, 32'd1);
    chk("str_beat4", 32'(beat_cnt2), 32'd4);
    chk("str_tlast", 32'(m_tlast), 32'd1);

    // Reset mid-stream discards buffered beats
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    chk("mid_level3", 32'(level), 32'd3);
    do_reset();
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_mvalid", 32'(m_tvalid), 32'd0);
    chk("mid_beat", beat_cnt, 32'd0);
    step(1'b1, 16'hABCD, 1'b0, 1'b0);
    chk("mid_first", 32'(m_tdata), 32'h0000ABCD);

    // Narrow counter wraps after 16
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 16'(i), 1'b1, 1'b1);
    chk("wrap_beat4", 32'(beat_cnt2), 32'd1);
    chk("wrap_pkt4", 32'(pkt_cnt2), 32'd1);
    chk("wrap_beat32", beat_cnt, 32'd17);

    // Randomized traffic, upstream holds stalled beats
    do_reset();
    v = 1'b0; d = '0; l = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      vprob = $urandom_range(20, 95);
      rprob = $urandom_range(10, 95);
      for (int c = 0; c < 150; c++) begin
        if (!(v && !m_pushed)) begin
          v = ($urandom_range(99) < vprob);
          d = 16'($urandom);
          l = ($urandom_range(3) == 0);
        end
        r = ($urandom_range(99) < rprob);
        if ($urandom_range(299) == 0) begin
          rst = 1'b1;
          step(v, d, l, r);
          rst = 1'b0;
        end else begin
          step(v, d, l, r);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
